// File: rtl/sram_like_pkg.sv
// Shared encodings for the sram-like arbiter: FSM states, bus owner, access sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_like_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_INST = 2'b01,
        OWN_DATA = 2'b10
    } owner_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'hF;

    // Increment that sticks at the 4-bit maximum instead of wrapping to 0.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == STARVE_MAX) ? STARVE_MAX : v + 4'd1;
    endfunction

endpackage

// File: rtl/sram_like_arb_pick.sv
// Grant selector: data wins unless inst has waited STARVE_LIMIT data grants.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result only while idle.
module sram_like_arb_pick
    import sram_like_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       inst_req,
    input  logic       data_req,
    input  logic [3:0] starve_cnt,
    output owner_t     next_owner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic inst_starved;
    assign inst_starved = inst_req && (starve_cnt >= LIMIT);

    // Fixed data priority, overridden once inst has been passed over too often.
    always_comb begin
        next_owner = OWN_NONE;
        if (data_req && !inst_starved) begin
            next_owner = OWN_DATA;
        end else if (inst_req) begin
            next_owner = OWN_INST;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave between inst fetch and load/store masters, one transaction at a time.
// Latency: request seen idle at t drives sl_req at t+1; address/ok paths are combinational pass-through.
// Backpressure: a master holds req until its addr_ok; the grant is held until the slave's data_ok.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          areset,

    input  logic          inst_req,
    input  logic          inst_wr,
    input  logic [1:0]    inst_size,
    input  logic [AW-1:0] inst_addr,
    input  logic [DW-1:0] inst_wdata,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,

    output logic          sl_req,
    output logic          sl_wr,
    output logic [1:0]    sl_size,
    output logic [AW-1:0] sl_addr,
    output logic [DW-1:0] sl_wdata,
    input  logic [DW-1:0] sl_rdata,
    input  logic          sl_addr_ok,
    input  logic          sl_data_ok
);

    state_t     state;
    owner_t     owner;
    logic [3:0] starve_cnt;
    owner_t     pick;

    sram_like_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .starve_cnt (starve_cnt),
        .next_owner (pick)
    );

    // Transaction FSM: grant in IDLE, address handshake in ADDR, wait for completion in DATA.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick != OWN_NONE) begin
                        owner <= pick;
                        state <= ST_ADDR;
                        // Only a data grant that bypasses a waiting inst counts toward starvation.
                        if (pick == OWN_DATA && inst_req) begin
                            starve_cnt <= sat_inc4(starve_cnt);
                        end else begin
                            starve_cnt <= 4'd0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sl_addr_ok) begin
                        if (sl_data_ok) begin
                            state <= ST_IDLE;
                            owner <= OWN_NONE;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sl_data_ok) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Route the owner's request onto the slave and the slave's oks back to the owner only.
    always_comb begin
        sl_req       = 1'b0;
        sl_wr        = 1'b0;
        sl_size      = 2'd0;
        sl_addr      = '0;
        sl_wdata     = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (state == ST_ADDR) begin
            sl_req = 1'b1;
            if (owner == OWN_INST) begin
                sl_wr        = inst_wr;
                sl_size      = inst_size;
                sl_addr      = inst_addr;
                sl_wdata     = inst_wdata;
                inst_addr_ok = sl_addr_ok;
                inst_data_ok = sl_addr_ok && sl_data_ok;
            end else if (owner == OWN_DATA) begin
                sl_wr        = data_wr;
                sl_size      = data_size;
                sl_addr      = data_addr;
                sl_wdata     = data_wdata;
                data_addr_ok = sl_addr_ok;
                data_data_ok = sl_addr_ok && sl_data_ok;
            end
        end else if (state == ST_DATA) begin
            inst_data_ok = (owner == OWN_INST) && sl_data_ok;
            data_data_ok = (owner == OWN_DATA) && sl_data_ok;
        end
    end

    // Read data is shared; forced low while reset is held so every output is quiet.
    assign inst_rdata = areset ? '0 : sl_rdata;
    assign data_rdata = areset ? '0 : sl_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: vector table, corner sequences, random vs. transaction model.
// Latency: inputs driven on negedge, outputs sampled 2 time units later.
// Backpressure: bench masters hold req until their addr_ok.
module tb_sram_like_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic          inst_req, inst_wr, data_req, data_wr;
    logic [1:0]    inst_size, data_size;
    logic [AW-1:0] inst_addr, data_addr;
    logic [DW-1:0] inst_wdata, data_wdata;
    logic [DW-1:0] inst_rdata, data_rdata;
    logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic          sl_req, sl_wr;
    logic [1:0]    sl_size;
    logic [AW-1:0] sl_addr;
    logic [DW-1:0] sl_wdata, sl_rdata;
    logic          sl_addr_ok, sl_data_ok;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .areset(areset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .sl_req(sl_req), .sl_wr(sl_wr), .sl_size(sl_size), .sl_addr(sl_addr), .sl_wdata(sl_wdata),
        .sl_rdata(sl_rdata), .sl_addr_ok(sl_addr_ok), .sl_data_ok(sl_data_ok)
    );

    wire [135:0] all_outs = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                             sl_req, sl_wr, sl_size, sl_addr, sl_wdata, inst_rdata, data_rdata};

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = '0; data_wdata = '0;
        sl_rdata = '0; sl_addr_ok = 0; sl_data_ok = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        idle_inputs();
        #1;
        chk("reset_outputs", 160'(all_outs), 160'd0);
        @(negedge clk);
        areset = 1'b0;
    endtask

    typedef struct {
        logic        d_req, d_wr;
        logic [1:0]  d_size;
        logic [31:0] d_addr, d_wdata;
        logic        a_ok, d_ok;
        logic [31:0] rdata;
        logic        e_req, e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        logic        e_daok, e_ddok;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic dr, input logic dw, input logic [1:0] ds, input logic [31:0] da,
                                input logic [31:0] dwd, input logic aok, input logic dok, input logic [31:0] rd,
                                input logic er, input logic ew, input logic [1:0] es, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic edaok, input logic eddok, input logic [31:0] erd);
        vec_t v;
        v.d_req = dr; v.d_wr = dw; v.d_size = ds; v.d_addr = da; v.d_wdata = dwd;
        v.a_ok = aok; v.d_ok = dok; v.rdata = rd;
        v.e_req = er; v.e_wr = ew; v.e_size = es; v.e_addr = ea; v.e_wdata = ewd;
        v.e_daok = edaok; v.e_ddok = eddok; v.e_rdata = erd;
        return v;
    endfunction

    vec_t tbl[11];

    // Transaction-level reference model state.
    int busy;     // 0 none, 1 inst, 2 data
    bit adone;    // address phase of the current transaction already accepted
    int run;      // consecutive data grants that bypassed a waiting inst

    initial begin
        string order;
        int    grants;
        bit    ip, dp, idrop, ddrop;
        logic  e_req, e_wr, e_aok, e_dok;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;

        areset = 1'b1;
        idle_inputs();

        // Table: single data read with slow slave, then a one-cycle write, then spurious oks while idle.
        tbl[0]  = mk(1,0,2,32'h1000,0,          0,0,0,           0,0,0,0,0,                       0,0,0);
        tbl[1]  = mk(1,0,2,32'h1000,0,          0,0,0,           1,0,2,32'h1000,0,                0,0,0);
        tbl[2]  = mk(1,0,2,32'h1000,0,          1,0,0,           1,0,2,32'h1000,0,                1,0,0);
        tbl[3]  = mk(0,0,0,0,0,                 0,0,0,           0,0,0,0,0,                       0,0,0);
        tbl[4]  = mk(0,0,0,0,0,                 0,1,32'hDEADBEEF,0,0,0,0,0,                       0,1,32'hDEADBEEF);
        tbl[5]  = mk(0,0,0,0,0,                 0,0,0,           0,0,0,0,0,                       0,0,0);
        tbl[6]  = mk(1,1,2,32'h2004,32'h12345678,0,0,0,          0,0,0,0,0,                       0,0,0);
        tbl[7]  = mk(1,1,2,32'h2004,32'h12345678,1,1,0,          1,1,2,32'h2004,32'h12345678,     1,1,0);
        tbl[8]  = mk(0,0,0,0,0,                 0,0,0,           0,0,0,0,0,                       0,0,0);
        tbl[9]  = mk(0,0,0,0,0,                 1,1,0,           0,0,0,0,0,                       0,0,0);
        tbl[10] = mk(0,0,0,0,0,                 0,0,0,           0,0,0,0,0,                       0,0,0);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            data_req = tbl[i].d_req; data_wr = tbl[i].d_wr; data_size = tbl[i].d_size;
            data_addr = tbl[i].d_addr; data_wdata = tbl[i].d_wdata;
            sl_addr_ok = tbl[i].a_ok; sl_data_ok = tbl[i].d_ok; sl_rdata = tbl[i].rdata;
            #2;
            chk($sformatf("vec%0d_slave", i), 160'({sl_req, sl_wr, sl_size, sl_addr, sl_wdata}),
                160'({tbl[i].e_req, tbl[i].e_wr, tbl[i].e_size, tbl[i].e_addr, tbl[i].e_wdata}));
            chk($sformatf("vec%0d_oks", i), 160'({data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok}),
                160'({tbl[i].e_daok, tbl[i].e_ddok, 2'b00}));
            chk($sformatf("vec%0d_rdata", i), 160'(data_rdata), 160'(tbl[i].e_rdata));
        end

        // Starvation: both masters always requesting, slave completes instantly.
        do_reset();
        inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200;
        sl_addr_ok = 1; sl_data_ok = 1;
        order  = "";
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #2;
            if (data_addr_ok) begin
                order = {order, "D"};
                if (grants == 3) chk("starve_cnt_at_limit", 160'(dut.starve_cnt), 160'd4);
                grants++;
            end
            if (inst_addr_ok) begin
                order = {order, "I"};
                chk("starve_cnt_after_inst", 160'(dut.starve_cnt), 160'd0);
                grants++;
            end
        end
        checks++;
        if (order.len() < 9 || order.substr(0, 8) != "DDDDIDDDD") begin
            errors++;
            $display("FAIL grant_order: got %s expected prefix DDDDIDDDD", order);
        end

        // Reset while inst owns the bus in DATA; a late data_ok after release must be dropped.
        do_reset();
        @(negedge clk); inst_req = 1; inst_addr = 32'h300;
        @(negedge clk); sl_addr_ok = 1; #2;
        chk("rst_seq_inst_addr_ok", 160'(inst_addr_ok), 160'd1);
        @(negedge clk); inst_req = 0; sl_addr_ok = 0; sl_rdata = 32'hA5A55A5A; #2;
        chk("rst_seq_in_data", 160'({sl_req, inst_data_ok}), 160'd0);
        #1; areset = 1; sl_data_ok = 1; #1;
        chk("rst_seq_outputs_zero", 160'(all_outs), 160'd0);
        @(negedge clk); areset = 0; sl_data_ok = 0;
        @(negedge clk); sl_data_ok = 1; #2;
        chk("rst_seq_late_data_ok", 160'({inst_data_ok, data_data_ok}), 160'd0);
        @(negedge clk); sl_data_ok = 0; inst_req = 1; inst_addr = 32'h400;
        @(negedge clk); sl_addr_ok = 1; #2;
        chk("rst_seq_regrant", 160'({sl_req, sl_addr, inst_addr_ok}), 160'({1'b1, 32'h400, 1'b1}));
        @(negedge clk); inst_req = 0; sl_addr_ok = 0; sl_data_ok = 1; #2;
        chk("rst_seq_regrant_done", 160'(inst_data_ok), 160'd1);

        // Data request arriving in the cycle the inst transaction completes.
        do_reset();
        @(negedge clk); inst_req = 1; inst_addr = 32'h500;
        @(negedge clk); sl_addr_ok = 1;
        @(negedge clk); inst_req = 0; sl_addr_ok = 0; sl_data_ok = 1; data_req = 1; data_addr = 32'h600; #2;
        chk("handoff_inst_data_ok", 160'(inst_data_ok), 160'd1);
        @(negedge clk); sl_data_ok = 0; #2;
        chk("handoff_idle_gap", 160'(sl_req), 160'd0);
        @(negedge clk); #2;
        chk("handoff_data_sl_req", 160'({sl_req, sl_addr}), 160'({1'b1, 32'h600}));
        @(negedge clk); sl_addr_ok = 1; sl_data_ok = 1; #2;
        chk("handoff_data_done", 160'({data_addr_ok, data_data_ok}), 160'({2'b11}));
        @(negedge clk); data_req = 0; sl_addr_ok = 0; sl_data_ok = 0;

        // Random traffic against the transaction-level model.
        do_reset();
        busy = 0; adone = 0; run = 0;
        ip = 0; dp = 0; idrop = 0; ddrop = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (idrop) begin inst_req = 0; ip = 0; idrop = 0; end
            if (ddrop) begin data_req = 0; dp = 0; ddrop = 0; end
            if (!ip && $urandom_range(0, 1) == 1) begin
                inst_req = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
                inst_addr = $urandom; inst_wdata = $urandom; ip = 1;
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
                data_addr = $urandom; data_wdata = $urandom; dp = 1;
            end
            sl_addr_ok = 1'($urandom_range(0, 1));
            sl_data_ok = ($urandom_range(0, 2) == 0);
            sl_rdata   = $urandom;
            #2;
            e_req = (busy != 0) && !adone;
            e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
            if (e_req && busy == 1) begin e_wr = inst_wr; e_size = inst_size; e_addr = inst_addr; e_wdata = inst_wdata; end
            if (e_req && busy == 2) begin e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata; end
            e_aok = e_req && sl_addr_ok;
            e_dok = (busy != 0) && (adone ? sl_data_ok : (sl_addr_ok && sl_data_ok));
            chk($sformatf("rand_cycle%0d", c), 160'(all_outs),
                160'({busy == 1 && e_aok, busy == 1 && e_dok, busy == 2 && e_aok, busy == 2 && e_dok,
                      e_req, e_wr, e_size, e_addr, e_wdata, sl_rdata, sl_rdata}));
            if (busy == 1 && e_aok) idrop = 1;
            if (busy == 2 && e_aok) ddrop = 1;
            if (busy == 0) begin
                if (data_req && !(inst_req && run >= LIM)) begin
                    busy = 2;
                    run  = inst_req ? ((run < 15) ? run + 1 : 15) : 0;
                end else if (inst_req) begin
                    busy = 1;
                    run  = 0;
                end
            end else if (e_dok) begin
                busy = 0; adone = 0;
            end else if (e_aok) begin
                adone = 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
